// File: rtl/obstacle_spawner.sv
// Dino runner obstacle spawner: schedules spawns from LFSR bits with a randomised
// cooldown and scrolls up to two live obstacles leftward once per game tick.
module obstacle_spawner #(
    parameter int RAND_BITS = 8,
    parameter int X_WIDTH   = 10,
    parameter int SCREEN_W  = 640,
    parameter int MIN_GAP   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_tick,
    input  logic                 running,
    input  logic [3:0]           speed,
    input  logic [RAND_BITS-1:0] lfsr_data,
    output logic                 obs0_valid,
    output logic [X_WIDTH-1:0]   obs0_x,
    output logic [1:0]           obs0_type,
    output logic                 obs1_valid,
    output logic [X_WIDTH-1:0]   obs1_x,
    output logic [1:0]           obs1_type,
    output logic                 spawn_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        COOLDOWN,
        ARMED
    } state_t;

    localparam logic [X_WIDTH-1:0] SPAWN_X = X_WIDTH'(SCREEN_W - 1);
    localparam logic [7:0]         GAP     = 8'(MIN_GAP);

    state_t             state, state_next;
    logic [7:0]         count, count_next;
    logic [1:0]         valid_q, valid_next;
    logic [X_WIDTH-1:0] x_q [2];
    logic [X_WIDTH-1:0] x_next [2];
    logic [1:0]         type_q [2];
    logic [1:0]         type_next [2];
    logic               pulse_next;
    logic               spawn;
    logic               slot;
    logic [7:0]         count_dec;
    logic [X_WIDTH-1:0] speed_ext;
    logic               unused_rand;

    assign speed_ext   = X_WIDTH'(speed);
    assign count_dec   = count - 8'd1;
    assign unused_rand = ^lfsr_data;

    // Free-slot decision uses pre-tick valids, so a slot freed on this tick waits a tick.
    assign slot = valid_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= 8'd0;
            valid_q     <= 2'b00;
            x_q[0]      <= '0;
            x_q[1]      <= '0;
            type_q[0]   <= 2'd0;
            type_q[1]   <= 2'd0;
            spawn_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            valid_q     <= valid_next;
            x_q[0]      <= x_next[0];
            x_q[1]      <= x_next[1];
            type_q[0]   <= type_next[0];
            type_q[1]   <= type_next[1];
            spawn_pulse <= pulse_next;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        valid_next   = valid_q;
        x_next[0]    = x_q[0];
        x_next[1]    = x_q[1];
        type_next[0] = type_q[0];
        type_next[1] = type_q[1];
        pulse_next   = 1'b0;
        spawn        = 1'b0;

        if (!running) begin
            state_next   = IDLE;
            count_next   = 8'd0;
            valid_next   = 2'b00;
            x_next[0]    = '0;
            x_next[1]    = '0;
            type_next[0] = 2'd0;
            type_next[1] = 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    count_next = GAP;
                    state_next = COOLDOWN;
                end
                COOLDOWN: begin
                    if (game_tick) begin
                        count_next = count_dec;
                        if (count_dec == 8'd0) begin
                            state_next = ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (game_tick && !(&valid_q)) begin
                        spawn      = 1'b1;
                        count_next = GAP + {4'b0000, lfsr_data[7:4]};
                        state_next = COOLDOWN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            // An obstacle that cannot move a full step has left the screen.
            if (game_tick) begin
                for (int i = 0; i < 2; i++) begin
                    if (valid_q[i]) begin
                        if (x_q[i] < speed_ext) begin
                            valid_next[i] = 1'b0;
                        end else begin
                            x_next[i] = x_q[i] - speed_ext;
                        end
                    end
                end
            end

            if (spawn) begin
                valid_next[slot] = 1'b1;
                x_next[slot]     = SPAWN_X;
                type_next[slot]  = lfsr_data[1:0];
                pulse_next       = 1'b1;
            end
        end
    end

    assign obs0_valid = valid_q[0];
    assign obs0_x     = x_q[0];
    assign obs0_type  = type_q[0];
    assign obs1_valid = valid_q[1];
    assign obs1_x     = x_q[1];
    assign obs1_type  = type_q[1];

endmodule
